pipe_ctrl_hazard: RTL and testbench
===================================

Name: pipe_ctrl_hazard

Overview:
- Consumer end of the opcode decoder interface: takes the decoder's per-instruction control bits in ID and carries them through ID/EX, EX/MEM and MEM/WB.
- Detects load-use hazards and inserts bubbles; resolves beq (EX) and j (ID) redirects with IF/ID flushes.
- Sits between the opcode decoder, the IF/ID register and the EX/MEM/WB datapath muxes of the 5-stage core.

Parameters:
REG_W, 5, register-specifier width
CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  synchronous, active-high reset
RegDst_i, ALUSrc_i, RegWrite_i, MemtoReg_i, MemWrite_i, Branch_i, Jump_i, ExtOp_i  in  1 each  decoder control bits for the instruction in ID
ALUOp_i  in  2  decoder ALU class for the instruction in ID
rs_i, rt_i, rd_i  in  REG_W each  register fields of the instruction in ID
Zero_i  in  1  ALU zero flag of the instruction in EX
PCWrite_o  out  1  PC load enable (comb)
IFIDWrite_o  out  1  IF/ID load enable (comb)
IFIDFlush_o  out  1  clear IF/ID to nop at next edge (comb)
PCSrc_o  out  1  select branch target (comb)
JumpSel_o  out  1  select jump target (comb)
ex_RegDst_o, ex_ALUSrc_o, ex_ExtOp_o, ex_Branch_o, ex_MemWrite_o, ex_MemtoReg_o, ex_RegWrite_o  out  1 each  ID/EX control (reg)
ex_ALUOp_o  out  2  ID/EX ALU class (reg)
ex_wreg_o  out  REG_W  EX destination: rd if RegDst else rt (reg)
mem_RegWrite_o, mem_MemtoReg_o, mem_MemWrite_o  out  1 each  EX/MEM control (reg)
mem_wreg_o  out  REG_W  EX/MEM destination (reg)
wb_RegWrite_o, wb_MemtoReg_o  out  1 each  MEM/WB control (reg)
wb_wreg_o  out  REG_W  MEM/WB destination (reg)
stall_cnt_o  out  CNT_W  load-use stall cycles since reset (reg)

Behaviour:
- Reset (rst_i high at an edge): every registered output 0, including ex_rt and stall_cnt_o; comb outputs then follow the zero state (PCWrite_o=1, IFIDWrite_o=1, others 0). Reset wins over every other event.
- Internal ex_rt (REG_W) latches rt_i together with the ID/EX control bits.
- uses_rt = RegDst_i | MemWrite_i | Branch_i.
- load_use = ex_MemtoReg_o & ex_RegWrite_o & (ex_rt != 0) & !Jump_i & (ex_rt == rs_i | (uses_rt & ex_rt == rt_i)).
- taken = ex_Branch_o & Zero_i.
- Priority: taken > load_use > Jump_i.
- taken: PCSrc_o=1, PCWrite_o=1, IFIDWrite_o=1, IFIDFlush_o=1, JumpSel_o=0; ID/EX loads bubble.
- load_use (not taken): PCWrite_o=0, IFIDWrite_o=0, IFIDFlush_o=0; ID/EX loads bubble; stall_cnt_o increments, saturating at 2^CNT_W-1.
- Jump_i only: JumpSel_o=1, IFIDFlush_o=1, PCWrite_o=1; ID/EX loads the jump's control (RegWrite=MemWrite=Branch=0).
- None: PCWrite_o=IFIDWrite_o=1, others 0; ID/EX loads decoder inputs.
- Bubble = all ID/EX control bits, ALUOp, ex_wreg_o and ex_rt set to 0.
- EX/MEM and MEM/WB always advance every cycle (no stall); EX/MEM takes ex_* values, MEM/WB takes mem_* values.
- Latency: decoder bits appear on ex_* 1 cycle, mem_* 2 cycles, wb_* 3 cycles after sampling, unless replaced by a bubble.
- Comb outputs depend only on current register state and current inputs; no combinational path from Zero_i to ex_*.

Test Plan:
- Reset held 2 cycles, then released with idle inputs -> all reg outputs 0, PCWrite_o=1, IFIDWrite_o=1, stall_cnt_o=0.
- lw $8 (rt=8, MemtoReg=1, RegWrite=1), then add with rs=8 in ID -> 1 cycle PCWrite_o=0, IFIDWrite_o=0; ex_* all 0 next cycle; stall_cnt_o=1; the add then reaches ex_* with ex_wreg_o=rd.
- lw $0 followed by use of $0 -> no stall; lw $8 followed by addi rt=8 (uses_rt=0) -> no stall.
- beq in EX with Zero_i=1 while a load_use condition holds in ID -> PCSrc_o=1, IFIDFlush_o=1, PCWrite_o=1; stall_cnt_o unchanged; ID/EX bubble.
- j in ID (Jump_i=1) behind a lw whose rt matches rs_i -> JumpSel_o=1, IFIDFlush_o=1, no stall.
- sw rt=5, RegWrite=0 -> mem_MemWrite_o=1 two cycles later; wb_RegWrite_o=0 three cycles later. With CNT_W=2, 4 stalls -> stall_cnt_o stays at 3.

Source files
------------

// File: rtl/pipe_ctrl_hazard_if.sv
// Decoder-to-hazard-unit bundle: control bits and register fields of the
// instruction in ID go in; PC/IF-ID steering and the staged control come out.
interface pipe_ctrl_hazard_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic             RegDst_i;
  logic             ALUSrc_i;
  logic             RegWrite_i;
  logic             MemtoReg_i;
  logic             MemWrite_i;
  logic             Branch_i;
  logic             Jump_i;
  logic             ExtOp_i;
  logic [1:0]       ALUOp_i;
  logic [REG_W-1:0] rs_i;
  logic [REG_W-1:0] rt_i;
  logic [REG_W-1:0] rd_i;
  logic             Zero_i;

  logic             PCWrite_o;
  logic             IFIDWrite_o;
  logic             IFIDFlush_o;
  logic             PCSrc_o;
  logic             JumpSel_o;

  logic             ex_RegDst_o;
  logic             ex_ALUSrc_o;
  logic             ex_ExtOp_o;
  logic             ex_Branch_o;
  logic             ex_MemWrite_o;
  logic             ex_MemtoReg_o;
  logic             ex_RegWrite_o;
  logic [1:0]       ex_ALUOp_o;
  logic [REG_W-1:0] ex_wreg_o;

  logic             mem_RegWrite_o;
  logic             mem_MemtoReg_o;
  logic             mem_MemWrite_o;
  logic [REG_W-1:0] mem_wreg_o;

  logic             wb_RegWrite_o;
  logic             wb_MemtoReg_o;
  logic [REG_W-1:0] wb_wreg_o;

  logic [CNT_W-1:0] stall_cnt_o;

  modport master (
    output RegDst_i, ALUSrc_i, RegWrite_i, MemtoReg_i, MemWrite_i, Branch_i,
           Jump_i, ExtOp_i, ALUOp_i, rs_i, rt_i, rd_i, Zero_i,
    input  PCWrite_o, IFIDWrite_o, IFIDFlush_o, PCSrc_o, JumpSel_o,
           ex_RegDst_o, ex_ALUSrc_o, ex_ExtOp_o, ex_Branch_o, ex_MemWrite_o,
           ex_MemtoReg_o, ex_RegWrite_o, ex_ALUOp_o, ex_wreg_o,
           mem_RegWrite_o, mem_MemtoReg_o, mem_MemWrite_o, mem_wreg_o,
           wb_RegWrite_o, wb_MemtoReg_o, wb_wreg_o, stall_cnt_o
  );

  modport slave (
    input  RegDst_i, ALUSrc_i, RegWrite_i, MemtoReg_i, MemWrite_i, Branch_i,
           Jump_i, ExtOp_i, ALUOp_i, rs_i, rt_i, rd_i, Zero_i,
    output PCWrite_o, IFIDWrite_o, IFIDFlush_o, PCSrc_o, JumpSel_o,
           ex_RegDst_o, ex_ALUSrc_o, ex_ExtOp_o, ex_Branch_o, ex_MemWrite_o,
           ex_MemtoReg_o, ex_RegWrite_o, ex_ALUOp_o, ex_wreg_o,
           mem_RegWrite_o, mem_MemtoReg_o, mem_MemWrite_o, mem_wreg_o,
           wb_RegWrite_o, wb_MemtoReg_o, wb_wreg_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl_hazard.sv
// Control pipeline and hazard unit of the 5-stage core: carries decoder
// control bits ID -> EX -> MEM -> WB, inserts load-use bubbles and flushes
// IF/ID on taken beq (resolved in EX) and j (resolved in ID).
module pipe_ctrl_hazard #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  pipe_ctrl_hazard_if.slave bus
);

  // Saturating +1 for the stall-cycle counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // ---- ID stage (p0): hazard detection on current decoder outputs ----
  logic uses_rt_p0;
  logic load_use_p0;
  logic taken_p0;
  logic bubble_p0;
  logic pc_write_p0;
  logic ifid_write_p0;
  logic ifid_flush_p0;
  logic pc_src_p0;
  logic jump_sel_p0;

  // ---- ID/EX register (p1) ----
  logic             regdst_p1;
  logic             alusrc_p1;
  logic             extop_p1;
  logic             branch_p1;
  logic             memwrite_p1;
  logic             memtoreg_p1;
  logic             regwrite_p1;
  logic [1:0]       aluop_p1;
  logic [REG_W-1:0] wreg_p1;
  logic [REG_W-1:0] rt_p1;

  // ---- EX/MEM register (p2) ----
  logic             regwrite_p2;
  logic             memtoreg_p2;
  logic             memwrite_p2;
  logic [REG_W-1:0] wreg_p2;

  // ---- MEM/WB register (p3) ----
  logic             regwrite_p3;
  logic             memtoreg_p3;
  logic [REG_W-1:0] wreg_p3;

  logic [CNT_W-1:0] stall_cnt;

  // A load in EX only hurts if ID actually reads its destination; a jump in
  // ID reads no registers, and $0 is never a real dependency.
  assign uses_rt_p0  = bus.RegDst_i | bus.MemWrite_i | bus.Branch_i;
  assign load_use_p0 = memtoreg_p1 & regwrite_p1 & (rt_p1 != '0) & ~bus.Jump_i &
                       ((rt_p1 == bus.rs_i) | (uses_rt_p0 & (rt_p1 == bus.rt_i)));
  assign taken_p0    = branch_p1 & bus.Zero_i;

  // Steering decision: taken branch beats load-use stall beats jump.
  always_comb begin
    pc_write_p0   = 1'b1;
    ifid_write_p0 = 1'b1;
    ifid_flush_p0 = 1'b0;
    pc_src_p0     = 1'b0;
    jump_sel_p0   = 1'b0;
    bubble_p0     = 1'b0;
    if (taken_p0) begin
      pc_src_p0     = 1'b1;
      ifid_flush_p0 = 1'b1;
      bubble_p0     = 1'b1;
    end else if (load_use_p0) begin
      pc_write_p0   = 1'b0;
      ifid_write_p0 = 1'b0;
      bubble_p0     = 1'b1;
    end else if (bus.Jump_i) begin
      jump_sel_p0   = 1'b1;
      ifid_flush_p0 = 1'b1;
    end
  end

  // ID/EX: load decoder bits, or a bubble; a jump never writes, stores or branches.
  always_ff @(posedge clk_i) begin
    if (rst_i || bubble_p0) begin
      regdst_p1   <= 1'b0;
      alusrc_p1   <= 1'b0;
      extop_p1    <= 1'b0;
      branch_p1   <= 1'b0;
      memwrite_p1 <= 1'b0;
      memtoreg_p1 <= 1'b0;
      regwrite_p1 <= 1'b0;
      aluop_p1    <= 2'b00;
      wreg_p1     <= '0;
      rt_p1       <= '0;
    end else begin
      regdst_p1   <= bus.RegDst_i;
      alusrc_p1   <= bus.ALUSrc_i;
      extop_p1    <= bus.ExtOp_i;
      branch_p1   <= bus.Branch_i & ~bus.Jump_i;
      memwrite_p1 <= bus.MemWrite_i & ~bus.Jump_i;
      memtoreg_p1 <= bus.MemtoReg_i;
      regwrite_p1 <= bus.RegWrite_i & ~bus.Jump_i;
      aluop_p1    <= bus.ALUOp_i;
      wreg_p1     <= bus.RegDst_i ? bus.rd_i : bus.rt_i;
      rt_p1       <= bus.rt_i;
    end
  end

  // EX/MEM and MEM/WB advance unconditionally every cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      regwrite_p2 <= 1'b0;
      memtoreg_p2 <= 1'b0;
      memwrite_p2 <= 1'b0;
      wreg_p2     <= '0;
      regwrite_p3 <= 1'b0;
      memtoreg_p3 <= 1'b0;
      wreg_p3     <= '0;
    end else begin
      regwrite_p2 <= regwrite_p1;
      memtoreg_p2 <= memtoreg_p1;
      memwrite_p2 <= memwrite_p1;
      wreg_p2     <= wreg_p1;
      regwrite_p3 <= regwrite_p2;
      memtoreg_p3 <= memtoreg_p2;
      wreg_p3     <= wreg_p2;
    end
  end

  // Count cycles actually lost to load-use stalls (a taken branch overrides).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
    end else if (load_use_p0 && !taken_p0) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

  assign bus.PCWrite_o      = pc_write_p0;
  assign bus.IFIDWrite_o    = ifid_write_p0;
  assign bus.IFIDFlush_o    = ifid_flush_p0;
  assign bus.PCSrc_o        = pc_src_p0;
  assign bus.JumpSel_o      = jump_sel_p0;

  assign bus.ex_RegDst_o    = regdst_p1;
  assign bus.ex_ALUSrc_o    = alusrc_p1;
  assign bus.ex_ExtOp_o     = extop_p1;
  assign bus.ex_Branch_o    = branch_p1;
  assign bus.ex_MemWrite_o  = memwrite_p1;
  assign bus.ex_MemtoReg_o  = memtoreg_p1;
  assign bus.ex_RegWrite_o  = regwrite_p1;
  assign bus.ex_ALUOp_o     = aluop_p1;
  assign bus.ex_wreg_o      = wreg_p1;

  assign bus.mem_RegWrite_o = regwrite_p2;
  assign bus.mem_MemtoReg_o = memtoreg_p2;
  assign bus.mem_MemWrite_o = memwrite_p2;
  assign bus.mem_wreg_o     = wreg_p2;

  assign bus.wb_RegWrite_o  = regwrite_p3;
  assign bus.wb_MemtoReg_o  = memtoreg_p3;
  assign bus.wb_wreg_o      = wreg_p3;

  assign bus.stall_cnt_o    = stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl_hazard.sv
// Bench for pipe_ctrl_hazard: an instruction-level pipeline model checked
// against the DUT every cycle, plus directed literal expectations.
module tb_pipe_ctrl_hazard;
  localparam int REG_W   = 5;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = 3;

  typedef struct packed {
    logic       regdst, alusrc, regwrite, memtoreg, memwrite, branch, jump, extop;
    logic [1:0] aluop;
    logic [4:0] rs, rt, rd;
  } id_t;

  typedef struct {
    bit       regdst, alusrc, extop, branch, memwrite, memtoreg, regwrite;
    bit [1:0] aluop;
    bit [4:0] wreg, rt;
  } ctl_t;

  typedef struct {
    bit pcwrite, ifidwrite, flush, pcsrc, jumpsel, bubble, stall;
  } dec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   en  = 1'b0;
  int   total = 0;
  int   bad   = 0;

  id_t  cur;
  bit   cur_z;
  ctl_t stg[3];
  int   m_stalls;

  pipe_ctrl_hazard_if #(.REG_W(REG_W), .CNT_W(CNT_W)) ifc ();
  pipe_ctrl_hazard #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  // Instruction constructors
  function automatic id_t i_idle();
    id_t d; d = '0; return d;
  endfunction
  function automatic id_t i_lw(bit [4:0] rs, bit [4:0] rt);
    id_t d; d = '0; d.memtoreg = 1; d.regwrite = 1; d.alusrc = 1; d.extop = 1;
    d.rs = rs; d.rt = rt; return d;
  endfunction
  function automatic id_t i_add(bit [4:0] rs, bit [4:0] rt, bit [4:0] rd);
    id_t d; d = '0; d.regdst = 1; d.regwrite = 1; d.aluop = 2'd2;
    d.rs = rs; d.rt = rt; d.rd = rd; return d;
  endfunction
  function automatic id_t i_addi(bit [4:0] rs, bit [4:0] rt);
    id_t d; d = '0; d.alusrc = 1; d.regwrite = 1; d.extop = 1; d.aluop = 2'd0;
    d.rs = rs; d.rt = rt; return d;
  endfunction
  function automatic id_t i_sw(bit [4:0] rs, bit [4:0] rt);
    id_t d; d = '0; d.memwrite = 1; d.alusrc = 1; d.extop = 1;
    d.rs = rs; d.rt = rt; return d;
  endfunction

  // What ID/EX must hold for an instruction entering EX
  function automatic ctl_t enter_ex(id_t d);
    ctl_t c;
    c.regdst   = d.regdst;
    c.alusrc   = d.alusrc;
    c.extop    = d.extop;
    c.memtoreg = d.memtoreg;
    c.aluop    = d.aluop;
    c.rt       = d.rt;
    c.wreg     = d.regdst ? d.rd : d.rt;
    c.regwrite = d.jump ? 1'b0 : d.regwrite;
    c.memwrite = d.jump ? 1'b0 : d.memwrite;
    c.branch   = d.jump ? 1'b0 : d.branch;
    return c;
  endfunction

  function automatic ctl_t nop_ctl();
    ctl_t c;
    c = '{default: 0};
    return c;
  endfunction

  // Hazard rules applied to the instruction in EX and the one in ID
  function automatic dec_t decide(ctl_t ex, id_t d, bit zero);
    dec_t r;
    bit   reads_rt;
    bit   hazard;
    reads_rt = d.regdst || d.memwrite || d.branch;
    hazard   = ex.memtoreg && ex.regwrite && (ex.rt != 0) && !d.jump &&
               ((ex.rt == d.rs) || (reads_rt && (ex.rt == d.rt)));
    r = '{pcwrite: 1, ifidwrite: 1, default: 0};
    if (ex.branch && zero) begin
      r.pcsrc = 1; r.flush = 1; r.bubble = 1;
    end else if (hazard) begin
      r.pcwrite = 0; r.ifidwrite = 0; r.bubble = 1; r.stall = 1;
    end else if (d.jump) begin
      r.jumpsel = 1; r.flush = 1;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic put(input id_t d, input bit z);
    cur = d; cur_z = z;
    ifc.RegDst_i   = d.regdst;
    ifc.ALUSrc_i   = d.alusrc;
    ifc.RegWrite_i = d.regwrite;
    ifc.MemtoReg_i = d.memtoreg;
    ifc.MemWrite_i = d.memwrite;
    ifc.Branch_i   = d.branch;
    ifc.Jump_i     = d.jump;
    ifc.ExtOp_i    = d.extop;
    ifc.ALUOp_i    = d.aluop;
    ifc.rs_i       = d.rs;
    ifc.rt_i       = d.rt;
    ifc.rd_i       = d.rd;
    ifc.Zero_i     = z;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Model: advance the instruction pipeline one cycle
  always @(posedge clk) begin
    dec_t r;
    if (rst) begin
      stg[0] = nop_ctl(); stg[1] = nop_ctl(); stg[2] = nop_ctl();
      m_stalls = 0;
    end else begin
      r = decide(stg[0], cur, cur_z);
      stg[2] = stg[1];
      stg[1] = stg[0];
      stg[0] = r.bubble ? nop_ctl() : enter_ex(cur);
      if (r.stall && m_stalls < CNT_MAX) m_stalls++;
    end
  end

  // Compare every DUT output against the model mid-cycle
  always @(negedge clk) begin
    dec_t r;
    if (en) begin
      r = decide(stg[0], cur, cur_z);
      chk("PCWrite",      ifc.PCWrite_o,      r.pcwrite);
      chk("IFIDWrite",    ifc.IFIDWrite_o,    r.ifidwrite);
      chk("IFIDFlush",    ifc.IFIDFlush_o,    r.flush);
      chk("PCSrc",        ifc.PCSrc_o,        r.pcsrc);
      chk("JumpSel",      ifc.JumpSel_o,      r.jumpsel);
      chk("ex_RegDst",    ifc.ex_RegDst_o,    stg[0].regdst);
      chk("ex_ALUSrc",    ifc.ex_ALUSrc_o,    stg[0].alusrc);
      chk("ex_ExtOp",     ifc.ex_ExtOp_o,     stg[0].extop);
      chk("ex_Branch",    ifc.ex_Branch_o,    stg[0].branch);
      chk("ex_MemWrite",  ifc.ex_MemWrite_o,  stg[0].memwrite);
      chk("ex_MemtoReg",  ifc.ex_MemtoReg_o,  stg[0].memtoreg);
      chk("ex_RegWrite",  ifc.ex_RegWrite_o,  stg[0].regwrite);
      chk("ex_ALUOp",     ifc.ex_ALUOp_o,     stg[0].aluop);
      chk("ex_wreg",      ifc.ex_wreg_o,      stg[0].wreg);
      chk("mem_RegWrite", ifc.mem_RegWrite_o, stg[1].regwrite);
      chk("mem_MemtoReg", ifc.mem_MemtoReg_o, stg[1].memtoreg);
      chk("mem_MemWrite", ifc.mem_MemWrite_o, stg[1].memwrite);
      chk("mem_wreg",     ifc.mem_wreg_o,     stg[1].wreg);
      chk("wb_RegWrite",  ifc.wb_RegWrite_o,  stg[2].regwrite);
      chk("wb_MemtoReg",  ifc.wb_MemtoReg_o,  stg[2].memtoreg);
      chk("wb_wreg",      ifc.wb_wreg_o,      stg[2].wreg);
      chk("stall_cnt",    ifc.stall_cnt_o,    m_stalls);
    end
  end

  task automatic load_use_round();
    put(i_lw(5'd1, 5'd8), 0);        tick();
    put(i_add(5'd8, 5'd9, 5'd10), 0); tick();
    tick();
    put(i_idle(), 0);
  endtask

  initial begin
    id_t d;
    put(i_idle(), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    en = 1'b1;
    tick();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_PCWrite",   ifc.PCWrite_o,     1);
    chk("rst_IFIDWrite", ifc.IFIDWrite_o,   1);
    chk("rst_stall_cnt", ifc.stall_cnt_o,   0);
    chk("rst_ex_RegWr",  ifc.ex_RegWrite_o, 0);
    chk("rst_wb_wreg",   ifc.wb_wreg_o,     0);
    tick();

    // lw $8 then add rs=8: one stall cycle
    put(i_lw(5'd1, 5'd8), 0); tick();
    put(i_add(5'd8, 5'd9, 5'd10), 0);
    @(negedge clk);
    chk("lu_PCWrite",   ifc.PCWrite_o,   0);
    chk("lu_IFIDWrite", ifc.IFIDWrite_o, 0);
    tick();
    @(negedge clk);
    chk("lu_bubble_RegWr", ifc.ex_RegWrite_o,  0);
    chk("lu_bubble_wreg",  ifc.ex_wreg_o,      0);
    chk("lu_stall_cnt",    ifc.stall_cnt_o,    1);
    chk("lu_mem_MemtoReg", ifc.mem_MemtoReg_o, 1);
    chk("lu_mem_wreg",     ifc.mem_wreg_o,     8);
    tick();
    @(negedge clk);
    chk("lu_add_wreg",  ifc.ex_wreg_o,     10);
    chk("lu_add_RegDst", ifc.ex_RegDst_o,  1);
    chk("lu_wb_wreg",   ifc.wb_wreg_o,     8);
    chk("lu_wb_MemtoReg", ifc.wb_MemtoReg_o, 1);
    put(i_idle(), 0); tick();

    // lw $0 then use of $0: no stall
    put(i_lw(5'd1, 5'd0), 0); tick();
    put(i_add(5'd0, 5'd0, 5'd3), 0);
    @(negedge clk);
    chk("zero_PCWrite", ifc.PCWrite_o, 1);
    tick();
    // lw $8 then addi rt=8: rt is not read, no stall
    put(i_lw(5'd1, 5'd8), 0); tick();
    put(i_addi(5'd1, 5'd8), 0);
    @(negedge clk);
    chk("addi_IFIDWrite", ifc.IFIDWrite_o, 1);
    tick();
    put(i_idle(), 0); tick();

    // Taken branch in EX overrides a load-use hazard in ID
    d = i_lw(5'd1, 5'd8); d.branch = 1; d.aluop = 2'd1;
    put(d, 0); tick();
    put(i_add(5'd8, 5'd9, 5'd10), 1);
    @(negedge clk);
    chk("br_PCSrc",   ifc.PCSrc_o,     1);
    chk("br_Flush",   ifc.IFIDFlush_o, 1);
    chk("br_PCWrite", ifc.PCWrite_o,   1);
    tick();
    @(negedge clk);
    chk("br_stall_cnt", ifc.stall_cnt_o,   1);
    chk("br_bubble",    ifc.ex_RegWrite_o, 0);
    put(i_idle(), 0); tick();
    // Same pair, branch not taken: stall counts
    put(d, 0); tick();
    put(i_add(5'd8, 5'd9, 5'd10), 0); tick();
    @(negedge clk);
    chk("nt_stall_cnt", ifc.stall_cnt_o, 2);
    tick();
    put(i_idle(), 0); tick();

    // j behind a matching lw: no stall, jump flushes; dirty write bits dropped
    put(i_lw(5'd1, 5'd8), 0); tick();
    d = '0; d.jump = 1; d.rs = 5'd8; d.rt = 5'd4; d.regwrite = 1; d.memwrite = 1; d.branch = 1;
    put(d, 0);
    @(negedge clk);
    chk("j_JumpSel", ifc.JumpSel_o,   1);
    chk("j_Flush",   ifc.IFIDFlush_o, 1);
    chk("j_PCWrite", ifc.PCWrite_o,   1);
    tick();
    @(negedge clk);
    chk("j_ex_RegWrite", ifc.ex_RegWrite_o, 0);
    chk("j_ex_MemWrite", ifc.ex_MemWrite_o, 0);
    chk("j_ex_wreg",     ifc.ex_wreg_o,     4);
    chk("j_stall_cnt",   ifc.stall_cnt_o,   2);
    put(i_idle(), 0); tick();

    // sw rt=5 down the pipe
    put(i_sw(5'd2, 5'd5), 0); tick();
    put(i_idle(), 0); tick();
    @(negedge clk);
    chk("sw_mem_MemWrite", ifc.mem_MemWrite_o, 1);
    chk("sw_mem_wreg",     ifc.mem_wreg_o,     5);
    tick();
    @(negedge clk);
    chk("sw_wb_RegWrite", ifc.wb_RegWrite_o, 0);
    chk("sw_wb_wreg",     ifc.wb_wreg_o,     5);
    tick();

    // Four more stalls saturate the 2-bit counter at 3
    for (int k = 0; k < 4; k++) begin
      load_use_round();
      @(negedge clk);
      chk("sat_stall_cnt", ifc.stall_cnt_o, 3);
      tick();
    end

    // Reset during an active hazard clears everything
    put(i_lw(5'd1, 5'd8), 0); tick();
    put(i_add(5'd8, 5'd9, 5'd10), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    put(i_idle(), 0);
    @(negedge clk);
    chk("rst2_stall_cnt", ifc.stall_cnt_o,   0);
    chk("rst2_ex_RegWr",  ifc.ex_RegWrite_o, 0);
    chk("rst2_PCWrite",   ifc.PCWrite_o,     1);
    tick();
    tick();

    en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
